// File: rtl/tortoise_pkg.sv
// Shared types for the issue path: the scoreboard entry and the issue arbiter port limit.
package tortoise_pkg;

  localparam int ISSUE_ARB_MAX_PORTS = 8;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [7:0]  op;
    logic [4:0]  rd;
  } scoreboard_entry_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: lowest requesting index at or above ptr, wrapping below it.
module rr_pick #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int          idx;
  logic [IW-1:0] sel;

  // Scan from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      sel = IW'(idx);
      if (req[sel]) begin
        gnt      = '0;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_arbiter.sv
// Round-robin issue arbiter feeding a one-entry output buffer towards the scoreboard.
// Optional per-port grant counters are built when ISSUE_ARB_PERF_EN is defined.
module issue_arbiter
  import tortoise_pkg::*;
#(
  parameter  int NR_PORTS = 2,
  localparam int PW       = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         debug_mode_i,
  input  logic [NR_PORTS-1:0]          req_valid_i,
  input  scoreboard_entry_t [NR_PORTS-1:0] req_instr_i,
  output logic [NR_PORTS-1:0]          req_pop_o,
  input  logic                         sb_ready_i,
  output logic                         sb_valid_o,
  output scoreboard_entry_t            sb_instr_o,
`ifdef ISSUE_ARB_PERF_EN
  output logic [NR_PORTS-1:0][31:0]    perf_grant_cnt_o,
`endif
  output logic [PW-1:0]                sb_port_o
);

  // Handshake: an entry moves to the scoreboard in any cycle where sb_valid_o and
  // sb_ready_i are both high; a source is popped in the cycle its req_pop_o bit is
  // high, which only happens while its req_valid_i bit is high.

  logic              buf_valid_q;
  scoreboard_entry_t buf_instr_q;
  logic [PW-1:0]     buf_port_q;
  logic [PW-1:0]     rr_q;

  logic [NR_PORTS-1:0] pick_gnt;
  logic [PW-1:0]       pick_idx;
  logic                pick_any;
  logic                load_en;
  logic                grant;

  rr_pick #(.N(NR_PORTS)) u_rr_pick (
    .req     (req_valid_i),
    .ptr     (rr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // The buffer can take a new entry when empty or when its current entry leaves now.
  assign load_en    = ~buf_valid_q | sb_ready_i;
  assign grant      = load_en & ~flush_i & ~debug_mode_i & ~rst_i & pick_any;
  assign req_pop_o  = grant ? pick_gnt : '0;
  assign sb_valid_o = buf_valid_q & ~debug_mode_i;
  assign sb_instr_o = buf_instr_q;
  assign sb_port_o  = buf_port_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_valid_q <= 1'b0;
      buf_instr_q <= '0;
      buf_port_q  <= '0;
      rr_q        <= '0;
    end else begin
      if (flush_i) begin
        buf_valid_q <= 1'b0;
      end else if (!debug_mode_i) begin
        if (grant) begin
          buf_valid_q <= 1'b1;
          buf_instr_q <= req_instr_i[pick_idx];
          buf_port_q  <= pick_idx;
        end else if (sb_ready_i) begin
          buf_valid_q <= 1'b0;
        end
      end
      if (grant) begin
        rr_q <= (pick_idx == PW'(NR_PORTS - 1)) ? '0 : pick_idx + PW'(1);
      end
    end
  end

`ifdef ISSUE_ARB_PERF_EN
  logic [NR_PORTS-1:0][31:0] perf_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_cnt_q <= '0;
    end else if (grant) begin
      for (int p = 0; p < NR_PORTS; p++) begin
        if (pick_gnt[p]) perf_cnt_q[p] <= perf_cnt_q[p] + 32'd1;
      end
    end
  end

  assign perf_grant_cnt_o = perf_cnt_q;
`else
  // Counters are not built in this configuration.
`endif

endmodule
